// File: rtl/bn_act_pkg.sv
// Shared constants and saturation helper for the streaming batch-norm/activation stage.
package bn_act_pkg;

  localparam int ACT_LINEAR = 0;
  localparam int ACT_RELU   = 1;

  localparam int ROUND_FLOOR   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Clamp a signed value into the range of a signed field of the given width.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/bn_act_lane.sv
// One lane of the BN/activation datapath: multiply, bias + rounding, then shift/activate.
module bn_act_lane
  import bn_act_pkg::*;
#(
  parameter int BW_IN   = 12,
  parameter int BW_A    = 12,
  parameter int BW_B    = 16,
  parameter int BW_OUT  = 12,
  parameter int R_SHIFT = 6,
  parameter int ROUND   = ROUND_HALF_UP,
  parameter int ACT     = ACT_RELU,
  parameter int MAXVAL  = -1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic signed [BW_IN-1:0]  i_x,
  input  logic signed [BW_A-1:0]   i_a,
  input  logic signed [BW_B-1:0]   i_b,
  output logic signed [BW_OUT-1:0] o_y
);

  localparam int PW = BW_IN + BW_A;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND_C =
    (ROUND != 0) ? SW'(64'sd1 <<< (R_SHIFT - 1)) : SW'(64'sd0);
  localparam logic signed [63:0] CLIP_C =
    (MAXVAL > 0) ? 64'(MAXVAL) : (64'sd1 <<< (BW_OUT - 1)) - 64'sd1;

  logic signed [PW-1:0]   r_prod;
  logic signed [BW_B-1:0] r_b2;
  logic signed [SW-1:0]   r_sum;
  logic signed [SW-1:0]   w_sh;
  logic signed [63:0]     w_act;

  assign w_sh = r_sum >>> R_SHIFT;

  // Activation on the shifted sum: ReLU with clip, or plain signed saturation.
  always_comb begin
    w_act = 64'sd0;
    if (ACT == ACT_RELU) begin
      if (64'(w_sh) < 64'sd0) begin
        w_act = 64'sd0;
      end else if (64'(w_sh) > CLIP_C) begin
        w_act = CLIP_C;
      end else begin
        w_act = 64'(w_sh);
      end
    end else begin
      w_act = sat_signed(64'(w_sh), BW_OUT);
    end
  end

  // S2 product, S3 biased/rounded sum, S4 output register; all frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= '0;
      r_b2   <= '0;
      r_sum  <= '0;
      o_y    <= '0;
    end else if (i_en) begin
      r_prod <= PW'(i_a) * PW'(i_x);
      r_b2   <= i_b;
      r_sum  <= SW'(r_prod) + SW'(r_b2) + RND_C;
      o_y    <= w_act[BW_OUT-1:0];
    end
  end

endmodule

// File: rtl/bn_act_stream.sv
// Streaming batch-norm + activation: NO_CH channels over PAR lanes per beat, valid/ready,
// per-channel scale/bias register file and a sticky vector-framing error flag.
module bn_act_stream
  import bn_act_pkg::*;
#(
  parameter int NO_CH   = 16,
  parameter int PAR     = 4,
  parameter int BW_IN   = 12,
  parameter int BW_A    = 12,
  parameter int BW_B    = 16,
  parameter int BW_OUT  = 12,
  parameter int R_SHIFT = 6,
  parameter int ROUND   = ROUND_HALF_UP,
  parameter int ACT     = ACT_RELU,
  parameter int MAXVAL  = -1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_in_vld,
  output logic                       o_in_rdy,
  input  logic                       i_in_last,
  input  logic [PAR*BW_IN-1:0]       i_in_data,
  output logic                       o_out_vld,
  input  logic                       i_out_rdy,
  output logic                       o_out_last,
  output logic [PAR*BW_OUT-1:0]      o_out_data,
  input  logic                       i_cfg_we,
  input  logic [$clog2(NO_CH)-1:0]   i_cfg_addr,
  input  logic signed [BW_A-1:0]     i_cfg_a,
  input  logic signed [BW_B-1:0]     i_cfg_b,
  output logic                       o_err_sync
);

  localparam int NO_GRP = NO_CH / PAR;
  localparam int GRP_W  = (NO_GRP > 1) ? $clog2(NO_GRP) : 1;
  localparam int AW     = $clog2(NO_CH);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NO_GRP - 1);

  logic signed [BW_A-1:0] r_a [NO_CH];
  logic signed [BW_B-1:0] r_b [NO_CH];
  logic [GRP_W-1:0]       r_grp;
  logic                   r_err;
  logic [3:0]             r_vld;
  logic [3:0]             r_last;
  logic                   w_en;
  logic                   w_acc;

  assign w_en       = ~r_vld[3] | i_out_rdy;
  assign w_acc      = i_in_vld & w_en;
  assign o_in_rdy   = w_en;
  assign o_out_vld  = r_vld[3];
  assign o_out_last = r_last[3];
  assign o_err_sync = r_err;

  // Coefficient register file; a read in the same cycle as a write sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NO_CH; c++) begin
        r_a[c] <= '0;
        r_b[c] <= '0;
      end
    end else if (i_cfg_we && (int'(i_cfg_addr) < NO_CH)) begin
      r_a[i_cfg_addr] <= i_cfg_a;
      r_b[i_cfg_addr] <= i_cfg_b;
    end
  end

  // Group counter, framing check and the valid/last shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grp  <= '0;
      r_err  <= 1'b0;
      r_vld  <= 4'b0000;
      r_last <= 4'b0000;
    end else begin
      if (w_acc) begin
        if (i_in_last || (r_grp == GRP_LAST)) begin
          r_grp <= '0;
        end else begin
          r_grp <= r_grp + GRP_W'(1);
        end
        if (i_in_last != (r_grp == GRP_LAST)) begin
          r_err <= 1'b1;
        end
      end
      if (w_en) begin
        r_vld  <= {r_vld[2:0], w_acc};
        r_last <= {r_last[2:0], w_acc & i_in_last};
      end
    end
  end

  for (genvar j = 0; j < PAR; j++) begin : g_lane
    logic [AW-1:0]           w_ch;
    logic signed [BW_IN-1:0] r_x1;
    logic signed [BW_A-1:0]  r_a1;
    logic signed [BW_B-1:0]  r_b1;
    logic signed [BW_OUT-1:0] w_y;

    assign w_ch = AW'(int'(r_grp) * PAR + j);

    // S1: capture the lane sample together with its channel's coefficients.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_x1 <= '0;
        r_a1 <= '0;
        r_b1 <= '0;
      end else if (w_en) begin
        r_x1 <= i_in_data[j*BW_IN +: BW_IN];
        r_a1 <= r_a[w_ch];
        r_b1 <= r_b[w_ch];
      end
    end

    bn_act_lane #(
      .BW_IN  (BW_IN),
      .BW_A   (BW_A),
      .BW_B   (BW_B),
      .BW_OUT (BW_OUT),
      .R_SHIFT(R_SHIFT),
      .ROUND  (ROUND),
      .ACT    (ACT),
      .MAXVAL (MAXVAL)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .i_en(w_en),
      .i_x (r_x1),
      .i_a (r_a1),
      .i_b (r_b1),
      .o_y (w_y)
    );

    assign o_out_data[j*BW_OUT +: BW_OUT] = w_y;
  end

endmodule
